// File: rtl/text_console_pkg.sv
// text_console_pkg: shared geometry, control codes, FSM states and CGA colours for the text console
package text_console_pkg;
    localparam int COLS   = 60;
    localparam int ROWS   = 34;
    localparam int ADDR_W = 11;

    localparam logic [5:0] LAST_COL = 6'(COLS - 1);
    localparam logic [5:0] LAST_ROW = 6'(ROWS - 1);

    localparam logic [7:0] DEFAULT_ATTR = 8'h07;
    localparam logic [7:0] BLANK_CHAR   = 8'h20;

    localparam logic [7:0] NUL = 8'h00;
    localparam logic [7:0] BS  = 8'h08;
    localparam logic [7:0] LF  = 8'h0A;
    localparam logic [7:0] FF  = 8'h0C;
    localparam logic [7:0] CR  = 8'h0D;
    localparam logic [7:0] ESC = 8'h1B;

    localparam logic [3:0] CGA_BLACK      = 4'h0;
    localparam logic [3:0] CGA_BLUE       = 4'h1;
    localparam logic [3:0] CGA_GREEN      = 4'h2;
    localparam logic [3:0] CGA_CYAN       = 4'h3;
    localparam logic [3:0] CGA_RED        = 4'h4;
    localparam logic [3:0] CGA_MAGENTA    = 4'h5;
    localparam logic [3:0] CGA_BROWN      = 4'h6;
    localparam logic [3:0] CGA_LIGHT_GREY = 4'h7;
    localparam logic [3:0] CGA_DARK_GREY  = 4'h8;
    localparam logic [3:0] CGA_WHITE      = 4'hF;

    typedef enum logic [1:0] {CLR_SCREEN, IDLE, CLR_LINE} state_t;
endpackage

// File: rtl/text_cell_addr.sv
// text_cell_addr: (row, col) -> VRAM cell address row*COLS+col
//   row, col : text cell position
//   addr     : 11-bit cell address, 0..COLS*ROWS-1
// row*60 is formed as (row<<6)-(row<<2); mod-2048 arithmetic is exact because
// every legal result is below 2048.
module text_cell_addr
    import text_console_pkg::*;
(
    input  logic [5:0]        row,
    input  logic [5:0]        col,
    output logic [ADDR_W-1:0] addr
);
    logic [ADDR_W-1:0] row_w;
    assign row_w = {5'd0, row};
    assign addr  = (row_w << 6) - (row_w << 2) + {5'd0, col};
endmodule

// File: rtl/text_console.sv
// text_console: byte stream -> text-mode VRAM writes with cursor and control codes
//   clk_i, rst_n_i           : clock, async active-low reset
//   char_i, attr_i           : incoming byte and its CGA attribute
//   char_valid_i/ready_o     : byte handshake
//   vram_cea_o/ada_o/din_o   : single-cycle VRAM write strobe, address, {attr, char}
//   cursor_col_o/row_o       : registered cursor position
//   busy_o                   : screen or line clear in progress
// Optional macro TEXT_CONSOLE_ATTR_ESC_EN: ESC followed by a byte loads an internal
// attribute register, which then replaces attr_i.
module text_console
    import text_console_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic [7:0]        char_i,
    input  logic [7:0]        attr_i,
    input  logic              char_valid_i,
    output logic              char_ready_o,
    output logic              vram_cea_o,
    output logic [ADDR_W-1:0] vram_ada_o,
    output logic [15:0]       vram_din_o,
    output logic [5:0]        cursor_col_o,
    output logic [5:0]        cursor_row_o,
    output logic              busy_o
);
    state_t            state, state_n;
    logic [5:0]        col, row, col_n, row_n;
    logic [5:0]        clr_col, clr_row, clr_col_n, clr_row_n;
    logic [5:0]        wr_col, wr_row;
    logic [ADDR_W-1:0] wr_addr;
    logic [15:0]       wr_data;
    logic              wr, nl, accept, decode;
    logic [7:0]        cur_attr;

    assign char_ready_o = state == IDLE;
    assign accept       = char_valid_i && char_ready_o;
    assign cursor_col_o = col;
    assign cursor_row_o = row;

`ifdef TEXT_CONSOLE_ATTR_ESC_EN
    logic [7:0] attr_q;
    logic       armed;
    assign cur_attr = attr_q;
    // The byte after ESC is an attribute, never a character or control code.
    assign decode   = !armed && char_i != ESC;
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            attr_q <= DEFAULT_ATTR;
            armed  <= 1'b0;
        end else if (accept) begin
            armed  <= !armed && char_i == ESC;
            attr_q <= armed ? char_i : attr_q;
        end
    end
`else
    assign cur_attr = attr_i;
    assign decode   = 1'b1;
`endif

    // One address generator shared by the clear sweep and the cursor write path.
    text_cell_addr u_addr (
        .row  (wr_row),
        .col  (wr_col),
        .addr (wr_addr)
    );

    always_comb begin
        state_n   = state;
        col_n     = col;
        row_n     = row;
        clr_col_n = clr_col;
        clr_row_n = clr_row;
        wr        = 1'b0;
        wr_row    = row;
        wr_col    = col;
        wr_data   = {DEFAULT_ATTR, BLANK_CHAR};
        nl        = 1'b0;
        if (state != IDLE) begin
            wr        = 1'b1;
            wr_row    = clr_row;
            wr_col    = clr_col;
            clr_col_n = (clr_col == LAST_COL) ? 6'd0 : clr_col + 6'd1;
            if (clr_col == LAST_COL) begin
                if (state == CLR_LINE || clr_row == LAST_ROW) begin
                    state_n   = IDLE;
                    clr_row_n = 6'd0;
                end else begin
                    clr_row_n = clr_row + 6'd1;
                end
            end
        end else if (accept && decode) begin
            if (char_i >= 8'h20 && char_i <= 8'h7E) begin
                wr      = 1'b1;
                wr_data = {cur_attr, char_i};
                col_n   = col + 6'd1;
                nl      = col == LAST_COL;
            end else if (char_i == LF) begin
                nl = 1'b1;
            end else if (char_i == CR) begin
                col_n = 6'd0;
            end else if (char_i == BS && col != 6'd0) begin
                wr     = 1'b1;
                col_n  = col - 6'd1;
                wr_col = col - 6'd1;
            end else if (char_i == FF) begin
                col_n     = 6'd0;
                row_n     = 6'd0;
                clr_col_n = 6'd0;
                clr_row_n = 6'd0;
                state_n   = CLR_SCREEN;
            end
            // Rows wrap instead of scrolling; the new row is blanked in CLR_LINE.
            if (nl) begin
                col_n     = 6'd0;
                row_n     = (row == LAST_ROW) ? 6'd0 : row + 6'd1;
                clr_col_n = 6'd0;
                clr_row_n = row_n;
                state_n   = CLR_LINE;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state      <= CLR_SCREEN;
            col        <= 6'd0;
            row        <= 6'd0;
            clr_col    <= 6'd0;
            clr_row    <= 6'd0;
            vram_cea_o <= 1'b0;
            vram_ada_o <= '0;
            vram_din_o <= '0;
            busy_o     <= 1'b0;
        end else begin
            state      <= state_n;
            col        <= col_n;
            row        <= row_n;
            clr_col    <= clr_col_n;
            clr_row    <= clr_row_n;
            vram_cea_o <= wr;
            vram_ada_o <= wr_addr;
            vram_din_o <= wr_data;
            busy_o     <= state != IDLE;
        end
    end
endmodule
